// File: rtl/apb5_ctrl_pkg.sv
// Shared types and constants for the APB5 requester controller.
package apb5_ctrl_pkg;

    localparam int PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Width of a port index; a single port still needs one bit to carry it.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb5_rr_arbiter.sv
// Combinational round-robin pick: first requesting port after last_grant.
// The pointer register is held by the parent so it only advances on acceptance.
module apb5_rr_arbiter
    import apb5_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int LG_W = idx_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [LG_W-1:0]    last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    generate
        if (NUM_REQ == 1) begin : g_single
            logic unused_last_grant;
            assign unused_last_grant = &{1'b0, last_grant};
            // A lone port always wins whenever it asks.
            assign grant = req & {NUM_REQ{enable}};
        end else begin : g_rr
            logic [LG_W-1:0] idx;
            logic            found;
            // Scan ports starting one past the previous winner, wrapping around.
            always_comb begin
                grant = '0;
                found = 1'b0;
                idx   = '0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = LG_W'((int'(last_grant) + k) % NUM_REQ);
                    if (enable && !found && req[idx]) begin
                        grant[idx] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/apb5_req_arbiter.sv
// APB5 requester: shares one APB5 bus between NUM_REQ command ports using
// round-robin arbitration and the IDLE/SETUP/ACCESS transfer sequence.
// Optional feature: define APB5_WAKEUP_EN to add the PWAKEUP output; grants
// from IDLE then wait until PWAKEUP has been high for a cycle.
module apb5_req_arbiter
    import apb5_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
)(
    input  logic                               PCLK,
    input  logic                               PRESETN,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_strb,
    input  logic [NUM_REQ*PROT_W-1:0]          req_prot,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_err,
    output logic                               PSEL,
    output logic                               PENABLE,
    output logic                               PWRITE,
    output logic [ADDR_WIDTH-1:0]              PADDR,
    output logic [DATA_WIDTH-1:0]              PWDATA,
    output logic [DATA_WIDTH/8-1:0]            PSTRB,
    output logic [PROT_W-1:0]                  PPROT,
    input  logic [DATA_WIDTH-1:0]              PRDATA,
    input  logic                               PREADY,
    input  logic                               PSLVERR
`ifdef APB5_WAKEUP_EN
    ,
    output logic                               PWAKEUP
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG_W   = idx_width(NUM_REQ);

    // Widths follow the module parameters, so the command record lives here.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     strb;
        logic [PROT_W-1:0]     prot;
    } apb_cmd_t;

    apb_state_e            state_reg;
    logic [LG_W-1:0]       last_grant_reg;
    logic [LG_W-1:0]       owner_reg;
    apb_cmd_t              cmd_reg;
    apb_cmd_t              cmd_next;
    logic [NUM_REQ-1:0]    rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_err_reg;
    logic [NUM_REQ-1:0]    grant;
    logic [LG_W-1:0]       grant_idx;
    logic                  arb_enable;
    logic                  take;
    logic                  wake_ok;

`ifdef APB5_WAKEUP_EN
    logic pwakeup_reg;
    // Wake is raised by any pending request and held while a transfer is in flight.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) pwakeup_reg <= 1'b0;
        else          pwakeup_reg <= (|req_valid) || (state_reg != IDLE);
    end
    assign wake_ok = pwakeup_reg;
    assign PWAKEUP = pwakeup_reg;
`else
    assign wake_ok = 1'b1;
`endif

    // A new command can be taken from IDLE, or in the completing ACCESS cycle.
    assign arb_enable = PRESETN && (((state_reg == IDLE) && wake_ok) ||
                                    ((state_reg == ACCESS) && PREADY));

    apb5_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .enable     (arb_enable),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign take      = |grant;

    // Convert the one-hot grant into a port index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = LG_W'(i);
        end
    end

    // Gather the winning port's command; reads carry no data or strobes.
    always_comb begin
        cmd_next       = '0;
        cmd_next.write = req_write[grant_idx];
        cmd_next.addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_next.prot  = req_prot[int'(grant_idx)*PROT_W +: PROT_W];
        if (req_write[grant_idx]) begin
            cmd_next.wdata = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            cmd_next.strb  = req_strb[int'(grant_idx)*STRB_W +: STRB_W];
        end
    end

    // Transfer sequencer: latches commands, walks SETUP/ACCESS, returns responses.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_reg      <= IDLE;
            last_grant_reg <= LG_W'(NUM_REQ - 1);
            owner_reg      <= '0;
            cmd_reg        <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        cmd_reg        <= cmd_next;
                        owner_reg      <= grant_idx;
                        last_grant_reg <= grant_idx;
                        state_reg      <= SETUP;
                    end
                end
                SETUP: state_reg <= ACCESS;
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                        rsp_rdata_reg <= cmd_reg.write ? '0 : PRDATA;
                        rsp_err_reg   <= PSLVERR;
                        if (take) begin
                            cmd_reg        <= cmd_next;
                            owner_reg      <= grant_idx;
                            last_grant_reg <= grant_idx;
                            state_reg      <= SETUP;
                        end else begin
                            cmd_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign PSEL      = (state_reg != IDLE);
    assign PENABLE   = (state_reg == ACCESS);
    assign PWRITE    = cmd_reg.write;
    assign PADDR     = cmd_reg.addr;
    assign PWDATA    = cmd_reg.wdata;
    assign PSTRB     = cmd_reg.strb;
    assign PPROT     = cmd_reg.prot;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb5_req_arbiter.sv
// Self-checking bench for apb5_req_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level reference model.
module tb_apb5_req_arbiter;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              PCLK = 1'b0;
    logic              PRESETN;
    logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SW-1:0]  req_strb;
    logic [NR*3-1:0]   req_prot;
    logic [DW-1:0]     rsp_rdata, PWDATA, PRDATA;
    logic              rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]     PADDR;
    logic [SW-1:0]     PSTRB;
    logic [2:0]        PPROT;
`ifdef APB5_WAKEUP_EN
    logic              PWAKEUP;
`endif

    always #5 PCLK = ~PCLK;

    apb5_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
`ifdef APB5_WAKEUP_EN
        , .PWAKEUP(PWAKEUP)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester-side pending commands, one per port.
    bit            p_valid [NR];
    bit            p_write [NR];
    logic [AW-1:0] p_addr  [NR];
    logic [DW-1:0] p_wdata [NR];
    logic [SW-1:0] p_strb  [NR];
    logic [2:0]    p_prot  [NR];

    // Reference model: the transfer in flight, pending response, RR pointer.
    int            cyc = 0;
    int            last_g = NR - 1;
    bit            cur_act = 0;
    int            cur_port, cur_acc;
    bit            cur_write;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [SW-1:0] cur_strb;
    logic [2:0]    cur_prot;
    bit            rsp_pend = 0;
    int            rsp_port;
    logic [DW-1:0] rsp_data;
    bit            rsp_e;
    bit            wake_m = 0;

    task automatic set_cmd(input int p, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] pr);
        p_valid[p] = 1; p_write[p] = w; p_addr[p] = a;
        p_wdata[p] = d; p_strb[p] = s; p_prot[p] = pr;
    endtask

    task automatic rand_cmd(input int p);
        set_cmd(p, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom), 3'($urandom));
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = p_valid[i];
            req_write[i]            = p_write[i];
            req_addr[i*AW +: AW]    = p_addr[i];
            req_wdata[i*DW +: DW]   = p_wdata[i];
            req_strb[i*SW +: SW]    = p_strb[i];
            req_prot[i*3 +: 3]      = p_prot[i];
        end
    endtask

    // One clock: drive inputs, check every visible output against the model, advance.
    task automatic step(input bit rst, input bit rdy, input logic [DW-1:0] rd, input bit er);
        int  age, exp_g, idx;
        bit  completing, free, any_v, was_act, wake_ok;
        logic [NR-1:0] exp_ready;
        @(negedge PCLK);
        PRESETN = !rst; PREADY = rdy; PRDATA = rd; PSLVERR = er;
        drive_reqs();
        #1;
        if (rsp_pend) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(NR'(1) << rsp_port));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(rsp_data));
            chk("rsp_err",   64'(rsp_err),   64'(rsp_e));
        end else begin
            chk("rsp_idle", 64'(rsp_valid), 64'(0));
        end
        age = cyc - cur_acc;
        if (cur_act) begin
            chk("psel",    64'(PSEL),    64'(1));
            chk("penable", 64'(PENABLE), 64'(age >= 2));
            chk("pwrite",  64'(PWRITE),  64'(cur_write));
            chk("paddr",   64'(PADDR),   64'(cur_addr));
            chk("pwdata",  64'(PWDATA),  cur_write ? 64'(cur_wdata) : 64'(0));
            chk("pstrb",   64'(PSTRB),   cur_write ? 64'(cur_strb) : 64'(0));
            chk("pprot",   64'(PPROT),   64'(cur_prot));
        end else begin
            chk("psel_idle",    64'(PSEL),    64'(0));
            chk("penable_idle", 64'(PENABLE), 64'(0));
        end
`ifdef APB5_WAKEUP_EN
        chk("pwakeup", 64'(PWAKEUP), 64'(wake_m));
        wake_ok = wake_m;
`else
        wake_ok = 1'b1;
`endif
        completing = !rst && cur_act && (age >= 2) && rdy;
        free = !rst && (cur_act ? completing : wake_ok);
        exp_g = -1;
        any_v = 0;
        for (int k = 1; k <= NR; k++) begin
            idx = (last_g + k) % NR;
            if (p_valid[idx]) any_v = 1;
            if (exp_g < 0 && p_valid[idx]) exp_g = idx;
        end
        exp_ready = (free && exp_g >= 0) ? (NR'(1) << exp_g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        was_act = cur_act;
        @(posedge PCLK);
        if (rst) begin
            cur_act = 0; rsp_pend = 0; last_g = NR - 1; wake_m = 0;
        end else begin
            wake_m   = any_v || was_act;
            rsp_pend = completing;
            if (completing) begin
                rsp_port = cur_port;
                rsp_data = cur_write ? '0 : rd;
                rsp_e    = er;
                cur_act  = 0;
            end
            if (free && exp_g >= 0) begin
                cur_act = 1; cur_port = exp_g; cur_acc = cyc;
                cur_write = p_write[exp_g]; cur_addr = p_addr[exp_g];
                cur_wdata = p_wdata[exp_g]; cur_strb = p_strb[exp_g];
                cur_prot = p_prot[exp_g];
                p_valid[exp_g] = 0;
                last_g = exp_g;
            end
        end
        cyc++;
    endtask

    initial begin
        bit rst, rdy;
        for (int i = 0; i < NR; i++) set_cmd(i, 0, '0, '0, '0, '0);
        for (int i = 0; i < NR; i++) p_valid[i] = 0;
        PRESETN = 0; PREADY = 0; PRDATA = '0; PSLVERR = 0;
        drive_reqs();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK); #1;
        chk("rst_psel",  64'(PSEL), 0);      chk("rst_penable", 64'(PENABLE), 0);
        chk("rst_pwrite", 64'(PWRITE), 0);   chk("rst_paddr", 64'(PADDR), 0);
        chk("rst_pwdata", 64'(PWDATA), 0);   chk("rst_pstrb", 64'(PSTRB), 0);
        chk("rst_pprot", 64'(PPROT), 0);     chk("rst_ready", 64'(req_ready), 0);
        chk("rst_rspv", 64'(rsp_valid), 0);  chk("rst_rdata", 64'(rsp_rdata), 0);
        chk("rst_err", 64'(rsp_err), 0);
`ifdef APB5_WAKEUP_EN
        chk("rst_pwakeup", 64'(PWAKEUP), 0);
`endif

        // Single write from port 0, zero-wait completer.
        set_cmd(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 3'd0);
        repeat (5) step(0, 1, 32'h0, 0);

        // Read from port 1 with three wait states.
        set_cmd(1, 0, 8'h20, 32'hAAAA5555, 4'hF, 3'd2);
        repeat (2) step(0, 0, 32'h0, 0);
        repeat (3) step(0, 0, 32'h0, 0);
        repeat (4) step(0, 1, 32'h12345678, 0);

        // Both ports requesting continuously: alternating back-to-back grants.
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NR; i++) if (!p_valid[i]) rand_cmd(i);
            step(0, 1, $urandom, 0);
        end
        for (int i = 0; i < NR; i++) p_valid[i] = 0;
        repeat (4) step(0, 1, $urandom, 0);

        // Slave error on a write to 0xFF, then a clean read.
        set_cmd(0, 1, 8'hFF, 32'h0BADF00D, 4'h3, 3'd1);
        repeat (4) step(0, 1, 32'h0, 1);
        set_cmd(1, 0, 8'h44, 32'h0, 4'h0, 3'd0);
        repeat (5) step(0, 1, 32'hCAFE0001, 0);

        // Reset while ACCESS waits, then both ports request: port 0 first.
        set_cmd(0, 0, 8'h55, 32'h0, 4'h0, 3'd0);
        repeat (4) step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        rand_cmd(0); rand_cmd(1);
        repeat (8) step(0, 1, $urandom, 0);

        // Random traffic with random wait states, errors, drops and resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!p_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) rand_cmd(i);
                end else if ($urandom_range(0, 9) == 0) begin
                    p_valid[i] = 0;
                end
            end
            rdy = ($urandom_range(0, 2) != 0);
            rst = 0;
            if (cur_act && (cyc - cur_acc) >= 2 && !rdy && $urandom_range(0, 24) == 0) rst = 1;
            step(rst, rdy, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
